// File: rtl/controle_de_venda_pkg.sv
// ---------------------------------------------------------------------------
// controle_de_venda_pkg
// Shared definitions for the vending sale controller:
//   estado_t           - FSM state encoding
//   PRECO*_PADRAO      - default product prices, in balance units
//   ESTOQUE_INICIAL    - stock loaded per product when STOCK_COUNT_EN is built
//   maior()            - elaboration-time max helper for counter sizing
// ---------------------------------------------------------------------------
package controle_de_venda_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        CHARGE     = 3'd2,
        WAIT_DEBIT = 3'd3,
        DISPENSE   = 3'd4,
        ERROR      = 3'd5
    } estado_t;

    localparam int PRECO0_PADRAO = 5;
    localparam int PRECO1_PADRAO = 10;
    localparam int PRECO2_PADRAO = 15;
    localparam int PRECO3_PADRAO = 25;

    localparam logic [3:0] ESTOQUE_INICIAL = 4'd9;

    function automatic int maior(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tecla_sync.sv
// ---------------------------------------------------------------------------
// tecla_sync
// Two-flop synchronizer plus falling-edge detector for one active-low key.
// A press is reported as a single-cycle pulse on the synchronized 1->0
// transition, so holding a key down never produces a second press.
//   clock   - system clock
//   reset   - asynchronous, active-high; flops reset to 1 (key released)
//   tecla_n - raw active-low key, asynchronous to clock
//   pressao - one-cycle press pulse
// ---------------------------------------------------------------------------
module tecla_sync (
    input  logic clock,
    input  logic reset,
    input  logic tecla_n,
    output logic pressao
);

    // sinc[0], sinc[1]: synchronizer; sinc[2]: previous synchronized value
    logic [2:0] sinc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc <= 3'b111;
        end else begin
            sinc <= {sinc[1:0], tecla_n};
        end
    end

    assign pressao = sinc[2] & ~sinc[1];

endmodule

// File: rtl/controle_de_venda.sv
// ---------------------------------------------------------------------------
// controle_de_venda
// Sale controller for a four-product vending machine. A key selects the
// product, the confirm key checks the balance, the price is presented to the
// (slow) balance controller on gastoOut, the debit is awaited, and the
// product's motor is run.
//
// Optional build macro: STOCK_COUNT_EN - per-product stock counters (reset
// to 9); confirming an empty product goes straight to ERROR without charging.
// Without it stock is unlimited and no stock logic is built.
//
// Ports:
//   clock      - system clock
//   reset      - asynchronous, active-high
//   sel_n      - product keys, active-low, asynchronous
//   confirma_n - confirm key, active-low, asynchronous
//   saldoIn    - current balance from the balance controller
//   gastoOut   - spend request (nonzero only in CHARGE)
//   motor      - one-hot dispense motor drive
//   produto    - selected product index
//   armado     - a product is selected / purchase in progress
//   erro       - purchase refused or failed
//   produto_ok - one-cycle pulse when a dispense completes
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | nothing selected; confirm ignored
// ARMED      | product selected; waiting for confirm or reselection
// CHARGE     | gastoOut = price for HOLD_CYCLES
// WAIT_DEBIT | waiting for saldoIn to reach the latched expected balance
// DISPENSE   | motor[produto] on for MOTOR_CYCLES
// ERROR      | erro on for ERR_CYCLES
// ---------------------------------------------------------------------------
module controle_de_venda
    import controle_de_venda_pkg::*;
#(
    parameter int PRECO0         = PRECO0_PADRAO,
    parameter int PRECO1         = PRECO1_PADRAO,
    parameter int PRECO2         = PRECO2_PADRAO,
    parameter int PRECO3         = PRECO3_PADRAO,
    parameter int HOLD_CYCLES    = 16777216,
    parameter int TIMEOUT_CYCLES = 67108864,
    parameter int MOTOR_CYCLES   = 50000000,
    parameter int ERR_CYCLES     = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sel_n,
    input  logic       confirma_n,
    input  logic [5:0] saldoIn,
    output logic [5:0] gastoOut,
    output logic [3:0] motor,
    output logic [1:0] produto,
    output logic       armado,
    output logic       erro,
    output logic       produto_ok
);

    localparam int MAIOR_CICLO = maior(maior(HOLD_CYCLES, TIMEOUT_CYCLES),
                                       maior(MOTOR_CYCLES, ERR_CYCLES));
    localparam int CW = $clog2(MAIOR_CICLO + 1);

    localparam logic [CW-1:0] FIM_HOLD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FIM_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FIM_MOTOR   = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] FIM_ERR     = CW'(ERR_CYCLES - 1);

    localparam logic [5:0] P0 = 6'(PRECO0);
    localparam logic [5:0] P1 = 6'(PRECO1);
    localparam logic [5:0] P2 = 6'(PRECO2);
    localparam logic [5:0] P3 = 6'(PRECO3);

    // -----------------------------------------------------------------------
    // Key synchronization
    // -----------------------------------------------------------------------
    logic [3:0] press_sel;
    logic       press_conf;

    for (genvar i = 0; i < 4; i++) begin : g_sel
        tecla_sync u_sel (
            .clock   (clock),
            .reset   (reset),
            .tecla_n (sel_n[i]),
            .pressao (press_sel[i])
        );
    end

    tecla_sync u_conf (
        .clock   (clock),
        .reset   (reset),
        .tecla_n (confirma_n),
        .pressao (press_conf)
    );

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    produto_q, produto_d;
    logic [5:0]    esperado_q, esperado_d;
    logic          ok_q, ok_d;

    logic [5:0]    preco;
    logic          sel_algum;
    logic [1:0]    sel_idx;
    logic          sem_estoque;

    always_comb begin
        preco = P0;
        case (produto_q)
            2'd0:    preco = P0;
            2'd1:    preco = P1;
            2'd2:    preco = P2;
            default: preco = P3;
        endcase
    end

    // Lowest index wins on simultaneous presses
    always_comb begin
        sel_algum = |press_sel;
        sel_idx   = 2'd0;
        if (press_sel[0])      sel_idx = 2'd0;
        else if (press_sel[1]) sel_idx = 2'd1;
        else if (press_sel[2]) sel_idx = 2'd2;
        else if (press_sel[3]) sel_idx = 2'd3;
    end

`ifdef STOCK_COUNT_EN
    logic [3:0] estoque_q [4];
    logic       dispensou;

    assign dispensou   = (estado_q == DISPENSE) && (cnt_q == FIM_MOTOR);
    assign sem_estoque = (estoque_q[produto_q] == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                estoque_q[i] <= ESTOQUE_INICIAL;
            end
        end else if (dispensou && !sem_estoque) begin
            estoque_q[produto_q] <= estoque_q[produto_q] - 4'd1;
        end
    end
`else
    assign sem_estoque = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= IDLE;
            cnt_q      <= '0;
            produto_q  <= 2'd0;
            esperado_q <= 6'd0;
            ok_q       <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            produto_q  <= produto_d;
            esperado_q <= esperado_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        produto_d  = produto_q;
        esperado_d = esperado_q;
        ok_d       = 1'b0;

        case (estado_q)
            IDLE, ARMED: begin
                // Reselection takes precedence over a confirm in the same cycle
                if (sel_algum) begin
                    produto_d = sel_idx;
                    estado_d  = ARMED;
                end else if ((estado_q == ARMED) && press_conf) begin
                    if (sem_estoque || (preco > saldoIn)) begin
                        estado_d = ERROR;
                    end else begin
                        estado_d   = CHARGE;
                        esperado_d = saldoIn - preco;
                    end
                end
            end
            CHARGE: begin
                if (cnt_q == FIM_HOLD) estado_d = WAIT_DEBIT;
            end
            WAIT_DEBIT: begin
                if (saldoIn == esperado_q)     estado_d = DISPENSE;
                else if (cnt_q == FIM_TIMEOUT) estado_d = ERROR;
            end
            DISPENSE: begin
                if (cnt_q == FIM_MOTOR) begin
                    estado_d = IDLE;
                    ok_d     = 1'b1;
                end
            end
            ERROR: begin
                if (cnt_q == FIM_ERR) estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // One shared timer: cleared on every state change, idle while untimed
    always_comb begin
        if ((estado_d != estado_q) || (estado_q == IDLE) || (estado_q == ARMED)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // -----------------------------------------------------------------------
    assign gastoOut   = (estado_q == CHARGE) ? preco : 6'd0;
    assign motor      = (estado_q == DISPENSE) ? (4'b0001 << produto_q) : 4'b0000;
    assign produto    = produto_q;
    assign armado     = (estado_q != IDLE);
    assign erro       = (estado_q == ERROR);
    assign produto_ok = ok_q;

endmodule

// File: tb/tb_controle_de_venda.sv
module tb_controle_de_venda;

    localparam int HOLD = 4;
    localparam int TMO  = 16;
    localparam int MOT  = 8;
    localparam int ERRC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sel_n = 4'hF;
    logic       confirma_n = 1'b1;
    logic [5:0] saldoIn = 6'd0;
    logic [5:0] gastoOut;
    logic [3:0] motor;
    logic [1:0] produto;
    logic       armado;
    logic       erro;
    logic       produto_ok;

    controle_de_venda #(
        .PRECO0         (5),
        .PRECO1         (10),
        .PRECO2         (15),
        .PRECO3         (25),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .MOTOR_CYCLES   (MOT),
        .ERR_CYCLES     (ERRC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sel_n      (sel_n),
        .confirma_n (confirma_n),
        .saldoIn    (saldoIn),
        .gastoOut   (gastoOut),
        .motor      (motor),
        .produto    (produto),
        .armado     (armado),
        .erro       (erro),
        .produto_ok (produto_ok)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nome, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: phase + remaining cycles, keys seen through their
    // synchronizer delay (press acts three edges after the key goes low)
    // -----------------------------------------------------------------------
    typedef enum {M_IDLE, M_ARMED, M_CHARGE, M_WAIT, M_DISP, M_ERR} fase_t;

    fase_t      fase = M_IDLE;
    int         rem = 0;
    int         m_prod = 0;
    int         m_esp = 0;
    bit         m_ok = 1'b0;
    logic [3:0] hs1 = 4'hF, hs2 = 4'hF, hs3 = 4'hF;
    logic       hc1 = 1'b1, hc2 = 1'b1, hc3 = 1'b1;
    logic [3:0] ps;
    logic       pc;
    bit         vazio;
    int         estoque_m [4] = '{9, 9, 9, 9};

    function automatic int preco_m(input int p);
        case (p)
            0:       return 5;
            1:       return 10;
            2:       return 15;
            default: return 25;
        endcase
    endfunction

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            fase = M_IDLE; rem = 0; m_prod = 0; m_esp = 0; m_ok = 1'b0;
            hs1 = 4'hF; hs2 = 4'hF; hs3 = 4'hF;
            hc1 = 1'b1; hc2 = 1'b1; hc3 = 1'b1;
            for (int i = 0; i < 4; i++) estoque_m[i] = 9;
        end else begin
            ps   = hs3 & ~hs2;
            pc   = hc3 & ~hc2;
            m_ok = 1'b0;
`ifdef STOCK_COUNT_EN
            vazio = (estoque_m[m_prod] == 0);
`else
            vazio = 1'b0;
`endif
            case (fase)
                M_IDLE, M_ARMED: begin
                    if (ps != 4'h0) begin
                        for (int i = 3; i >= 0; i--) if (ps[i]) m_prod = i;
                        fase = M_ARMED;
                    end else if (fase == M_ARMED && pc) begin
                        if (vazio || preco_m(m_prod) > int'(saldoIn)) begin
                            fase = M_ERR; rem = ERRC;
                        end else begin
                            fase = M_CHARGE; rem = HOLD;
                            m_esp = int'(saldoIn) - preco_m(m_prod);
                        end
                    end
                end
                M_CHARGE: begin
                    rem--;
                    if (rem == 0) begin fase = M_WAIT; rem = TMO; end
                end
                M_WAIT: begin
                    if (int'(saldoIn) == m_esp) begin
                        fase = M_DISP; rem = MOT;
                    end else begin
                        rem--;
                        if (rem == 0) begin fase = M_ERR; rem = ERRC; end
                    end
                end
                M_DISP: begin
                    rem--;
                    if (rem == 0) begin
                        fase = M_IDLE; m_ok = 1'b1;
                        if (estoque_m[m_prod] > 0) estoque_m[m_prod]--;
                    end
                end
                default: begin
                    rem--;
                    if (rem == 0) fase = M_IDLE;
                end
            endcase
            hs3 = hs2; hs2 = hs1; hs1 = sel_n;
            hc3 = hc2; hc2 = hc1; hc1 = confirma_n;
        end
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare plus activity counters for literal checks
    // -----------------------------------------------------------------------
    int cyc = 0;
    int n_gasto = 0, n_motor = 0, n_ok = 0, n_erro = 0;
    int last_gasto = 0, first_erro = -1;

    initial forever begin
        @(negedge clock);
        cyc++;
        chk("gastoOut", gastoOut, (fase == M_CHARGE) ? preco_m(m_prod) : 0);
        chk("motor", motor, (fase == M_DISP) ? (1 << m_prod) : 0);
        chk("produto", produto, m_prod);
        chk("armado", armado, (fase != M_IDLE) ? 1 : 0);
        chk("erro", erro, (fase == M_ERR) ? 1 : 0);
        chk("produto_ok", produto_ok, m_ok ? 1 : 0);
        if (gastoOut != 6'd0) begin n_gasto++; last_gasto = cyc; end
        if (motor != 4'd0) n_motor++;
        if (produto_ok) n_ok++;
        if (erro) begin
            n_erro++;
            if (first_erro < 0) first_erro = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic zera();
        n_gasto = 0; n_motor = 0; n_ok = 0; n_erro = 0;
        last_gasto = 0; first_erro = -1;
    endtask

    task automatic press_sel(input int i);
        sel_n[i] = 1'b0;
        tick(3);
        sel_n = 4'hF;
        tick(3);
    endtask

    task automatic press_conf();
        confirma_n = 1'b0;
        tick(3);
        confirma_n = 1'b1;
        tick(3);
    endtask

    initial begin
        tick(3);
        chk("rst_gasto", gastoOut, 0);
        chk("rst_motor", motor, 0);
        chk("rst_produto", produto, 0);
        chk("rst_armado", armado, 0);
        chk("rst_erro", erro, 0);
        chk("rst_ok", produto_ok, 0);
        reset = 1'b0;
        tick(2);

        // successful purchase of product 1
        saldoIn = 6'd30; zera();
        press_sel(1);
        chk("s1_produto", produto, 1);
        chk("s1_armado", armado, 1);
        press_conf();
        saldoIn = 6'd20;
        tick(20);
        chk("s1_gasto_cycles", n_gasto, 4);
        chk("s1_motor_cycles", n_motor, 8);
        chk("s1_ok_pulses", n_ok, 1);
        chk("s1_armado_end", armado, 0);

        // key press during DISPENSE is discarded
        saldoIn = 6'd25; zera();
        press_sel(0);
        press_conf();
        saldoIn = 6'd20;
        tick(2);
        press_sel(3);
        tick(10);
        chk("s2_motor_cycles", n_motor, 8);
        chk("s2_armado_end", armado, 0);
        chk("s2_produto", produto, 0);

        // insufficient balance
        saldoIn = 6'd20; zera();
        press_sel(3);
        press_conf();
        tick(6);
        chk("s3_gasto_cycles", n_gasto, 0);
        chk("s3_erro_cycles", n_erro, 4);
        chk("s3_armado_end", armado, 0);

        // debit never arrives -> timeout
        saldoIn = 6'd50; zera();
        press_sel(2);
        press_conf();
        tick(30);
        chk("s4_gasto_cycles", n_gasto, 4);
        chk("s4_motor_cycles", n_motor, 0);
        chk("s4_erro_cycles", n_erro, 4);
        chk("s4_wait_gap", first_erro - last_gasto, 17);

        // confirm in IDLE is ignored
        zera();
        press_conf();
        tick(2);
        chk("s5_idle_gasto", n_gasto, 0);
        chk("s5_idle_erro", n_erro, 0);
        chk("s5_idle_armado", armado, 0);

        // simultaneous keys, then reselection
        saldoIn = 6'd0;
        sel_n = 4'h0;
        tick(3);
        sel_n = 4'hF;
        tick(3);
        chk("s6_lowest", produto, 0);
        chk("s6_armado", armado, 1);
        press_sel(2);
        chk("s6_reselect", produto, 2);
        press_conf();
        tick(6);
        chk("s6_armado_end", armado, 0);

        // reset during DISPENSE
        saldoIn = 6'd30;
        press_sel(1);
        press_conf();
        saldoIn = 6'd20;
        tick(3);
        chk("s7_motor_on", motor, 2);
        reset = 1'b1;
        #1;
        chk("s7_rst_motor", motor, 0);
        chk("s7_rst_gasto", gastoOut, 0);
        chk("s7_rst_produto", produto, 0);
        chk("s7_rst_armado", armado, 0);
        chk("s7_rst_erro", erro, 0);
        chk("s7_rst_ok", produto_ok, 0);
        tick(2);
        reset = 1'b0;
        saldoIn = 6'd30; zera();
        press_conf();
        tick(10);
        chk("s7_conf_gasto", n_gasto, 0);
        chk("s7_conf_motor", n_motor, 0);
        chk("s7_conf_armado", armado, 0);

`ifdef STOCK_COUNT_EN
        zera();
        for (int k = 0; k < 9; k++) begin
            saldoIn = 6'd50;
            press_sel(0);
            press_conf();
            saldoIn = 6'd45;
            tick(12);
        end
        chk("s8_ok_pulses", n_ok, 9);
        zera();
        saldoIn = 6'd50;
        press_sel(0);
        press_conf();
        tick(6);
        chk("s8_empty_gasto", n_gasto, 0);
        chk("s8_empty_erro", n_erro, 4);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_de_venda.md
CONTROLE_DE_VENDA -- requirements
Module: controle_de_venda

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  PRECO0, 5, price of product 0 in balance units (multiple of 5, 5..50).
  PRECO1, 10, price of product 1.
  PRECO2, 15, price of product 2.
  PRECO3, 25, price of product 3.
  HOLD_CYCLES, 16777216, cycles gastoOut holds the price (covers the slow balance clock).
  TIMEOUT_CYCLES, 67108864, maximum wait for the balance debit.
  MOTOR_CYCLES, 50000000, dispense motor on-time.
  ERR_CYCLES, 25000000, error indication time.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clock, in, 1, system clock.
  reset, in, 1, asynchronous, active-high.
  sel_n, in, 4, product keys, active-low, asynchronous to clock.
  confirma_n, in, 1, purchase confirm key, active-low.
  saldoIn, in, 6, current balance from the balance controller.
  gastoOut, out, 6, spend request to the balance controller.
  motor, out, 4, one-hot dispense motor drive.
  produto, out, 2, selected product index.
  armado, out, 1, a product is selected.
  erro, out, 1, purchase refused or failed.
  produto_ok, out, 1, one-cycle pulse when a dispense completes.

Function
REQ-003 All key inputs SHALL pass through a 2-flop synchronizer; a "press" is a synchronized 1->0 transition, detected once per press.
REQ-004 The FSM SHALL have states IDLE, ARMED, CHARGE, WAIT_DEBIT, DISPENSE and ERROR.
REQ-005 In IDLE or ARMED, a press on sel_n[i] SHALL set produto=i and armado=1 and move to ARMED. Simultaneous presses SHALL select the lowest index. Re-selecting in ARMED SHALL replace the selection.
REQ-006 In ARMED, a confirma_n press with price(produto) <= saldoIn SHALL move to CHARGE, latching esperado = saldoIn - price.
REQ-007 In ARMED, a confirma_n press with price > saldoIn SHALL move to ERROR. In IDLE, confirma_n SHALL be ignored.
REQ-008 In CHARGE, gastoOut SHALL equal price for exactly HOLD_CYCLES cycles, then return to 0 in the same cycle the FSM enters WAIT_DEBIT.
REQ-009 In WAIT_DEBIT, saldoIn == esperado SHALL move to DISPENSE. After TIMEOUT_CYCLES cycles without a match, the FSM SHALL move to ERROR.
REQ-010 In DISPENSE, motor[produto] SHALL be 1 for exactly MOTOR_CYCLES cycles. The FSM SHALL then pulse produto_ok for 1 cycle and return to IDLE with armado=0.
REQ-011 ERROR SHALL hold erro=1 for ERR_CYCLES cycles, then return to IDLE with armado=0.
REQ-012 Key presses in CHARGE, WAIT_DEBIT, DISPENSE and ERROR SHALL be discarded, not queued.
REQ-013 gastoOut SHALL be 0 in every state except CHARGE, so that each purchase presents a fresh nonzero value to the balance controller.
REQ-014 Price comparison and the esperado subtraction SHALL be 6-bit unsigned; no underflow is possible given REQ-006.
REQ-015 A single shared counter, wide enough for the largest parameter, SHALL time CHARGE, WAIT_DEBIT, DISPENSE and ERROR, and SHALL clear on every state entry.

Reset
REQ-016 Reset SHALL force IDLE immediately, including mid-operation.
REQ-017 Reset values SHALL be: gastoOut=0, motor=0, produto=0, armado=0, erro=0, produto_ok=0, counter=0, esperado=0, synchronizers=1 (released).

Configuration
REQ-018 With STOCK_COUNT_EN defined, the block SHALL hold a 4-bit stock counter per product, reset to 9, decremented on DISPENSE exit. A confirm on a product with stock 0 SHALL go to ERROR without charging.
REQ-019 Without STOCK_COUNT_EN, stock SHALL be unlimited and no stock logic SHALL exist.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the default price constants and the initial stock constant.
REQ-021 The synchronizer and press detector SHALL be one sub-module, tecla_sync, instantiated per key.

Verification (bench parameters: HOLD=4, TIMEOUT=16, MOTOR=8, ERR=4)
REQ-022 saldoIn=30, press sel_n[1], press confirma_n -> gastoOut=10 for 4 cycles, then 0; drive saldoIn=20 -> motor=0010 for 8 cycles, produto_ok pulse, IDLE.
REQ-023 saldoIn=20, select product 3 (price 25), confirm -> gastoOut stays 0, erro=1 for 4 cycles, then IDLE with armado=0.
REQ-024 saldoIn=50, select 2, confirm, saldoIn held at 50 -> ERROR after 16 WAIT_DEBIT cycles, motor stays 0.
REQ-025 sel_n=0000 in one cycle -> produto=0; then press sel_n[2] in ARMED -> produto=2.
REQ-026 Assert reset during DISPENSE -> motor=0 and all outputs at reset values immediately; a later confirm without a new selection is ignored.
REQ-027 With STOCK_COUNT_EN defined: 9 successful purchases of product 0, then a 10th confirm -> ERROR, gastoOut stays 0.
